// File: rtl/apb_master_bridge_if.sv
// ============================================================================
// apb_master_bridge_if : command/response and APB completer bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_strb;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  // Bridge side
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  // Requester / completer side
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
// apb_master_bridge : single-outstanding command/response to APB requester
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_master_bridge_if.master bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                r_state,  w_state_nxt;
  logic                  r_cmd_ready, w_cmd_ready;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
  logic                  r_rsp_err,   w_rsp_err;
  logic                  r_psel,      w_psel;
  logic                  r_penable,   w_penable;
  logic                  r_pwrite,    w_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr,     w_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata,    w_pwdata;
  logic [STRB_W-1:0]     r_pstrb,     w_pstrb;
  logic [CNT_W-1:0]      r_wait_cnt,  w_wait_cnt;
  logic                  w_timeout;

  // Fires on the TIMEOUT-th consecutive ACCESS cycle with PREADY low
  assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_pstrb     <= w_pstrb;
      r_wait_cnt  <= w_wait_cnt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = r_cmd_ready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_pstrb     = r_pstrb;
    w_wait_cnt  = r_wait_cnt;

    case (r_state)
      IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_pwrite    = bus.cmd_write;
          w_paddr     = bus.cmd_addr;
          w_pwdata    = bus.cmd_wdata;
          w_pstrb     = bus.cmd_write ? bus.cmd_strb : '0;
          w_psel      = 1'b1;
          w_penable   = 1'b0;
          w_cmd_ready = 1'b0;
          w_wait_cnt  = '0;
          w_state_nxt = SETUP;
        end
      end

      SETUP: begin
        w_penable   = 1'b1;
        w_state_nxt = ACCESS;
      end

      ACCESS: begin
        // Completion wins over timeout when both land on the same cycle
        if (bus.PREADY) begin
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_pwrite ? '0 : bus.PRDATA;
          w_rsp_err   = bus.PSLVERR;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b1;
          w_state_nxt = RESP;
        end else if (r_wait_cnt != {CNT_W{1'b1}}) begin
          w_wait_cnt  = r_wait_cnt + 1'b1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSTRB     = r_pstrb;

endmodule

`default_nettype wire

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of cmd_addr and PADDR.
REQ-002 Parameter DATA_WIDTH, 32, width of data buses; multiple of 8.
REQ-003 Parameter TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-005 PCLK  in  1  clock; all state updates on the rising edge.
REQ-006 PRESET  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data.
REQ-012 cmd_strb  in  DATA_WIDTH/8  write byte strobes.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts.
REQ-016 rsp_err  out  1  PSLVERR or timeout.
REQ-017 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-018 PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8.
REQ-019 PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1  completer response.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, and all outputs SHALL be registered.
REQ-021 IDLE: cmd_ready=1; on accept, capture write/addr/wdata/strb onto PWRITE/PADDR/PWDATA/PSTRB (PSTRB forced to 0 for reads) -> SETUP.
REQ-022 SETUP: PSEL=1 and PENABLE=0 for exactly one cycle -> ACCESS.
REQ-023 ACCESS: PSEL=1 and PENABLE=1; PADDR, PWRITE, PWDATA and PSTRB held stable until exit.
REQ-024 ACCESS with PREADY sampled high: rsp_rdata=PRDATA for reads (0 for writes), rsp_err=PSLVERR, PSEL=PENABLE=0 -> RESP.
REQ-025 A wait counter SHALL count ACCESS cycles with PREADY low; it clears on entry to SETUP.
REQ-026 When TIMEOUT is nonzero and the counter reaches TIMEOUT with PREADY still low, the block SHALL abort: PSEL=PENABLE=0, rsp_err=1, rsp_rdata=0 -> RESP; if PREADY is high on that cycle, normal completion takes priority.
REQ-027 RESP: rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready; on handshake rsp_valid=0 -> IDLE. cmd_ready=0 in every state except IDLE.
REQ-028 Zero-wait latency: command accepted at edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid high from N+3; each PREADY-low cycle adds one cycle.
REQ-029 Back-to-back commands SHALL incur at least one IDLE cycle between RESP handshake and next SETUP.
REQ-030 PADDR/PWDATA/PWRITE SHALL retain last transaction values in IDLE/RESP; only PSEL/PENABLE return to 0.

Reset
REQ-031 With PRESET high at a rising edge, the block SHALL enter IDLE, set cmd_ready=1, and clear all other outputs and the wait counter to 0, regardless of current state, including mid-ACCESS.
REQ-032 An in-flight transaction aborted by reset SHALL produce no response.

Verification
REQ-033 Write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY tied high -> PSEL rises at N+1, PENABLE at N+2, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
REQ-034 Read 0x10 with PREADY low 2 ACCESS cycles and PRDATA=0xDEADBEEF -> rsp_valid at N+5, rsp_rdata=0xDEADBEEF, PSTRB=0 throughout.
REQ-035 Write with PSLVERR=1 at completion -> rsp_err=1, and the next command is accepted normally.
REQ-036 TIMEOUT=16, PREADY stuck low -> PSEL drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; repeat with PREADY rising on cycle 16 -> normal completion.
REQ-037 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, and no PSEL activity until handshake.
REQ-038 PRESET asserted during ACCESS -> next edge PSEL=PENABLE=0, rsp_valid=0, cmd_ready=1, and no response is emitted.
